arb_req_client: RTL and testbench

Client-side requester for the two-way req/gnt arbiter: the other end of the arbiter's handshake. It accepts a transfer job from local logic, drives `req` toward the arbiter and holds it until it has been granted for the job's beat count. It then releases `req` and enforces a minimum idle gap before the next request. One instance sits beside each arbiter request port (`req_0`/`gnt_0`, `req_1`/`gnt_1`).

---
 rtl/arb_req_pkg.sv | 21 ++
 rtl/arb_req_gap_timer.sv | 36 +++
 rtl/arb_req_client.sv | 149 ++++++++++++++
 tb/tb_arb_req_client.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arb_req_pkg.sv
// Shared types and default constants for the arbiter request client.
// The optional wait-timeout path is enabled with the ARB_REQ_TIMEOUT_EN macro.
package arb_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int LEN_W_DEF       = 4;
    localparam int GAP_CYC_DEF     = 2;
    localparam int TIMEOUT_CYC_DEF = 15;

    // req is driven high exactly while a job is outstanding.
    function automatic logic is_req_state(input state_e s);
        return (s == ST_WAIT) || (s == ST_XFER);
    endfunction

endpackage

// File: rtl/arb_req_gap_timer.sv
// Loadable down-counter shared by the GAP countdown and the first-grant wait timeout.
// Decrements only when enabled and saturates at zero.
module arb_req_gap_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = cnt;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/arb_req_client.sv
// Client side of the req/gnt arbiter handshake: holds req until a job's beats are granted,
// then enforces an idle gap. ARB_REQ_TIMEOUT_EN builds the first-grant timeout path.
module arb_req_client
    import arb_req_pkg::*;
#(
    parameter int LEN_W       = LEN_W_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             xfer_active,
    output logic             done,
    output logic             timeout,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a beat is any rising edge with req=1 and gnt=1; gnt with req=0 is ignored.
    localparam int TMR_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_zero;

    logic             beat;
    logic             last_beat;
    logic             wait_expired;

    assign beat      = req_q & gnt;
    assign last_beat = beat && (beat_cnt_q == LEN_W'(1));

`ifdef ARB_REQ_TIMEOUT_EN
    assign wait_expired = (state_q == ST_WAIT) && !gnt && tmr_zero;
`else
    assign wait_expired = 1'b0;
`endif

    arb_req_gap_timer #(.W(TMR_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .cnt   (tmr_cnt),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            req_q      <= req_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        tmr_cnt    = '0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    state_d    = ST_WAIT;
                    beat_cnt_d = (job_len == '0) ? LEN_W'(1) : job_len;
                    tmr_load   = 1'b1;
                    tmr_cnt    = TO_LOAD;
                end
            end
            ST_WAIT: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    if (last_beat) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_cnt  = GAP_LOAD;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (wait_expired) begin
                    // Abandon the job: discard remaining beats and take the normal gap.
                    state_d    = ST_GAP;
                    beat_cnt_d = '0;
                    tmr_load   = 1'b1;
                    tmr_cnt    = GAP_LOAD;
                end else begin
                    tmr_dec = !gnt;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    if (last_beat) begin
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_cnt  = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_d     = is_req_state(state_d);
        done_d    = last_beat;
        timeout_d = wait_expired;
    end

    assign req         = req_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign xfer_active = req_q & gnt;
    assign job_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_arb_req_client.sv
// Self-checking bench for arb_req_client: directed scenarios plus random jobs, with expected
// edges for done/timeout/gap computed from the grant sequence at the transaction level.
module tb_arb_req_client;

    localparam int LEN_W       = 4;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 15;
    localparam int SEQ_N       = 64;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             job_valid = 1'b0;
    logic [LEN_W-1:0] job_len = '0;
    logic             gnt = 1'b0;
    logic             job_ready;
    logic             req;
    logic             xfer_active;
    logic             done;
    logic             timeout;
    logic             busy;
    logic [1:0]       state_dbg;

    int tests = 0;
    int fails = 0;
    bit gnt_seq[SEQ_N];

    arb_req_client #(
        .LEN_W       (LEN_W),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_len     (job_len),
        .job_ready   (job_ready),
        .req         (req),
        .gnt         (gnt),
        .xfer_active (xfer_active),
        .done        (done),
        .timeout     (timeout),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int pct);
        for (int i = 0; i < SEQ_N; i++) begin
            gnt_seq[i] = (i >= 40) ? 1'b1 : ($urandom_range(0, 99) < pct);
        end
    endtask

    task automatic fill_pattern(input int n_zero_lead, input bit all_ones);
        for (int i = 0; i < SEQ_N; i++) begin
            gnt_seq[i] = all_ones ? 1'b1 : (i >= n_zero_lead);
        end
    endtask

    // Accept a job at edge 0; gnt before edge k is gnt_seq[k-1]. Outputs are sampled
    // just before each edge k and compared with values derived from the beat edges.
    task automatic run_job(input int len, input string name);
        int  len_eff;
        int  beats;
        int  d_edge;
        int  to_edge;
        int  end_edge;
        int  first_gnt;
        logic exp_req;
        logic exp_busy;
        len_eff   = (len == 0) ? 1 : len;
        beats     = 0;
        d_edge    = -1;
        to_edge   = -1;
        first_gnt = -1;
        for (int i = 0; i < SEQ_N; i++) begin
            if (gnt_seq[i] && first_gnt < 0) first_gnt = i;
        end
`ifdef ARB_REQ_TIMEOUT_EN
        if (first_gnt < 0 || first_gnt >= TIMEOUT_CYC) to_edge = TIMEOUT_CYC;
`endif
        if (to_edge < 0) begin
            for (int i = 0; i < SEQ_N; i++) begin
                if (gnt_seq[i] && d_edge < 0) begin
                    beats++;
                    if (beats == len_eff) d_edge = i + 1;
                end
            end
        end
        end_edge = (to_edge > 0) ? to_edge : d_edge;

        @(negedge clock);
        gnt       = 1'($urandom_range(0, 1));
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        #1;
        check({name, "_k0_ready"}, job_ready, 1'b1);
        check({name, "_k0_busy"}, busy, 1'b0);
        check({name, "_k0_req"}, req, 1'b0);
        check({name, "_k0_xfer"}, xfer_active, 1'b0);

        for (int k = 1; k <= end_edge + GAP_CYC + 1; k++) begin
            @(negedge clock);
            gnt       = (k <= end_edge) ? gnt_seq[k-1] : 1'($urandom_range(0, 1));
            job_valid = (k > end_edge) && (k <= end_edge + GAP_CYC);
            job_len   = LEN_W'($urandom_range(0, 15));
            #1;
            exp_req  = (k <= end_edge);
            exp_busy = (k <= end_edge + GAP_CYC);
            check({name, "_req"}, req, exp_req);
            check({name, "_xfer"}, xfer_active, exp_req & gnt_seq[(k <= end_edge) ? k-1 : 0] & (k <= end_edge));
            check({name, "_done"}, done, (d_edge > 0) && (k == d_edge + 1));
            check({name, "_timeout"}, timeout, (to_edge > 0) && (k == to_edge + 1));
            check({name, "_busy"}, busy, exp_busy);
            check({name, "_ready"}, job_ready, !exp_busy);
        end
        job_valid = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        gnt = 1'b1;
        #1;
        check("rst_req", req, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", job_ready, 1'b1);
        check("rst_xfer", xfer_active, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        fill_pattern(0, 1'b1);
        run_job(3, "len3");
        fill_pattern(0, 1'b1);
        run_job(0, "len0");
        for (int i = 0; i < SEQ_N; i++) gnt_seq[i] = 1'b1;
        gnt_seq[2] = 1'b0;
        gnt_seq[3] = 1'b0;
        run_job(4, "stall");
`ifdef ARB_REQ_TIMEOUT_EN
        fill_pattern(SEQ_N, 1'b0);
        run_job(5, "tmo");
`else
        fill_pattern(20, 1'b0);
        run_job(2, "notmo");
`endif
        fill_pattern(0, 1'b1);
        run_job(15, "len15");

        // Reset mid-transfer with two beats left.
        @(negedge clock);
        gnt       = 1'b1;
        job_valid = 1'b1;
        job_len   = LEN_W'(4);
        @(negedge clock);
        job_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("mid_req_before", req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_req", req, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_ready", job_ready, 1'b1);
        check("mid_xfer", xfer_active, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        fill_pattern(0, 1'b1);
        run_job(1, "post_rst");

        for (int j = 0; j < 20; j++) begin
            fill_random(60);
            run_job($urandom_range(0, 15), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
